// File: rtl/pe_pkg.sv
// Shared PE packet format: header codes, injector states and packing helpers.
// Latency: none (combinational functions and constants only).
// Backpressure: not applicable; used by both the injector and the PE decoder.
package pe_pkg;

    localparam int FILTER_WIDTH = 8;
    localparam int PACKET_WIDTH = 3 * FILTER_WIDTH + 4;

    // Header = {row[1:0], is_filter, ts}
    localparam logic [3:0] HDR_F1    = 4'b0110;
    localparam logic [3:0] HDR_F2    = 4'b1010;
    localparam logic [3:0] HDR_F3    = 4'b1110;
    localparam logic [3:0] HDR_IF_T0 = 4'b0000;

    typedef enum logic [2:0] {
        INJ_IDLE,
        INJ_F1,
        INJ_F2,
        INJ_F3,
        INJ_WAIT_IF,
        INJ_SEND_IF,
        INJ_DONE
    } inj_state_e;

    // Filter row r (1..3) carries w(3r-3), w(3r-2), w(3r-1), first weight in the MSBs.
    function automatic logic [PACKET_WIDTH-1:0] pack_filter_row(
        input logic [9*FILTER_WIDTH-1:0] weights,
        input logic [1:0]                row
    );
        logic [3:0] hdr;
        int         base;
        case (row)
            2'd1: begin hdr = HDR_F1; base = 0; end
            2'd2: begin hdr = HDR_F2; base = 3; end
            default: begin hdr = HDR_F3; base = 6; end
        endcase
        return {weights[base*FILTER_WIDTH +: FILTER_WIDTH],
                weights[(base+1)*FILTER_WIDTH +: FILTER_WIDTH],
                weights[(base+2)*FILTER_WIDTH +: FILTER_WIDTH],
                hdr};
    endfunction

    // Rows are laid out bottom row first in the MSBs, pixels left to right within a row.
    function automatic logic [PACKET_WIDTH-1:0] pack_ifmap(
        input logic [8:0] pix,
        input logic       ts
    );
        return {{(PACKET_WIDTH-13){1'b0}},
                pix[6], pix[7], pix[8],
                pix[3], pix[4], pix[5],
                pix[0], pix[1], pix[2],
                HDR_IF_T0 | {3'b000, ts}};
    endfunction

endpackage

// File: rtl/pe_packet_injector.sv
// Packetizer feeding the PE: filter rows 1-3 once, then one ifmap packet per timestep.
// Latency: first packet valid 1 cycle after start; ifmap packet valid 1 cycle after window handshake.
// Backpressure: pkt_data/pkt_valid held until pkt_ready; ifmap_ready only while waiting for a window.
module pe_packet_injector
    import pe_pkg::*;
#(
    parameter int FILTER_WIDTH  = pe_pkg::FILTER_WIDTH,
    parameter int PACKET_WIDTH  = 28,
    parameter int NUM_TIMESTEPS = 2,
    parameter int TS_WIDTH      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [9*FILTER_WIDTH-1:0] filter_in,
    input  logic                      ifmap_valid,
    output logic                      ifmap_ready,
    input  logic [8:0]                ifmap_in,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [PACKET_WIDTH-1:0]   pkt_data,
    output logic [TS_WIDTH-1:0]       ts_idx,
    output logic                      busy,
    output logic                      done
);

    if (PACKET_WIDTH != 3 * FILTER_WIDTH + 4) begin : g_bad_packet_width
        $error("pe_packet_injector: PACKET_WIDTH must equal 3*FILTER_WIDTH+4");
    end
    // The wire format is shared with the PE decoder through pe_pkg.
    if (FILTER_WIDTH != pe_pkg::FILTER_WIDTH) begin : g_bad_filter_width
        $error("pe_packet_injector: FILTER_WIDTH must match pe_pkg::FILTER_WIDTH");
    end
    if (NUM_TIMESTEPS < 1 || (1 << TS_WIDTH) < NUM_TIMESTEPS) begin : g_bad_timesteps
        $error("pe_packet_injector: need NUM_TIMESTEPS >= 1 and 2**TS_WIDTH >= NUM_TIMESTEPS");
    end

    localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(NUM_TIMESTEPS - 1);

    inj_state_e                state;
    logic [9*FILTER_WIDTH-1:0] filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INJ_IDLE;
            filt_q      <= '0;
            pkt_data    <= '0;
            pkt_valid   <= 1'b0;
            ifmap_ready <= 1'b0;
            ts_idx      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                INJ_IDLE: begin
                    if (start) begin
                        filt_q    <= filter_in;
                        ts_idx    <= '0;
                        pkt_data  <= pack_filter_row(filter_in, 2'd1);
                        pkt_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= INJ_F1;
                    end
                end
                INJ_F1: begin
                    if (pkt_ready) begin
                        pkt_data <= pack_filter_row(filt_q, 2'd2);
                        state    <= INJ_F2;
                    end
                end
                INJ_F2: begin
                    if (pkt_ready) begin
                        pkt_data <= pack_filter_row(filt_q, 2'd3);
                        state    <= INJ_F3;
                    end
                end
                INJ_F3: begin
                    if (pkt_ready) begin
                        pkt_valid   <= 1'b0;
                        ifmap_ready <= 1'b1;
                        state       <= INJ_WAIT_IF;
                    end
                end
                INJ_WAIT_IF: begin
                    if (ifmap_valid) begin
                        ifmap_ready <= 1'b0;
                        pkt_data    <= pack_ifmap(ifmap_in, ts_idx[0]);
                        pkt_valid   <= 1'b1;
                        state       <= INJ_SEND_IF;
                    end
                end
                INJ_SEND_IF: begin
                    if (pkt_ready) begin
                        pkt_valid <= 1'b0;
                        if (ts_idx == TS_LAST) begin
                            done  <= 1'b1;
                            state <= INJ_DONE;
                        end else begin
                            ts_idx      <= ts_idx + TS_WIDTH'(1);
                            ifmap_ready <= 1'b1;
                            state       <= INJ_WAIT_IF;
                        end
                    end
                end
                INJ_DONE: begin
                    busy  <= 1'b0;
                    state <= INJ_IDLE;
                end
                default: begin
                    pkt_valid   <= 1'b0;
                    ifmap_ready <= 1'b0;
                    busy        <= 1'b0;
                    state       <= INJ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_packet_injector.sv
// Bench: two injectors (2 and 4 timesteps) on shared stimulus, checked against a queue model.
module tb_pe_packet_injector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [71:0] filter_in = '0;
    logic        ifmap_valid = 1'b0;
    logic [8:0]  ifmap_in = '0;
    logic        pkt_ready = 1'b0;

    logic        ifmap_ready0, pkt_valid0, busy0, done0;
    logic [27:0] pkt_data0;
    logic [0:0]  ts_idx0;
    logic        ifmap_ready1, pkt_valid1, busy1, done1;
    logic [27:0] pkt_data1;
    logic [1:0]  ts_idx1;

    pe_packet_injector #(.FILTER_WIDTH(8), .PACKET_WIDTH(28), .NUM_TIMESTEPS(2), .TS_WIDTH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .filter_in(filter_in),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready0), .ifmap_in(ifmap_in),
        .pkt_valid(pkt_valid0), .pkt_ready(pkt_ready), .pkt_data(pkt_data0),
        .ts_idx(ts_idx0), .busy(busy0), .done(done0));

    pe_packet_injector #(.FILTER_WIDTH(8), .PACKET_WIDTH(28), .NUM_TIMESTEPS(4), .TS_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .filter_in(filter_in),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready1), .ifmap_in(ifmap_in),
        .pkt_valid(pkt_valid1), .pkt_ready(pkt_ready), .pkt_data(pkt_data1),
        .ts_idx(ts_idx1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam logic [71:0] FILT = 72'h09_08_07_06_05_04_03_02_01;
    logic [27:0] lit[5] = '{28'h0102036, 28'h040506A, 28'h070809E, 28'h0001550, 28'h0001FF1};
    logic [8:0]  win[4] = '{9'h155, 9'h1FF, 9'h0AA, 9'h111};

    // ---------------- reference model ----------------
    bit          m_run[2], m_fin[2];
    int          m_need[2], m_ts[2], m_cnt[2];
    logic [27:0] m_q[2][4];

    function automatic int n_ts(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [27:0] exp_row(input logic [71:0] f, input int r);
        logic [27:0] p;
        p = 28'((r << 2) | 2);
        for (int j = 0; j < 3; j++)
            p = p | (28'(f[(3*(r-1)+j)*8 +: 8]) << (20 - 8*j));
        return p;
    endfunction

    function automatic logic [27:0] exp_if(input logic [8:0] px, input int ts);
        logic [27:0] p;
        p = 28'(ts & 1);
        for (int k = 0; k < 9; k++)
            if (px[k]) p[4 + 3*(k/3) + (2 - k%3)] = 1'b1;
        return p;
    endfunction

    task automatic m_push(input int d, input logic [27:0] v);
        m_q[d][m_cnt[d]] = v;
        m_cnt[d]++;
    endtask

    task automatic m_step(input int d);
        if (!m_run[d]) begin
            if (start) begin
                m_run[d] = 1; m_fin[d] = 0; m_ts[d] = 0; m_need[d] = n_ts(d);
                for (int r = 1; r <= 3; r++) m_push(d, exp_row(filter_in, r));
            end
        end else if (m_fin[d]) begin
            m_fin[d] = 0; m_run[d] = 0;
        end else if (m_cnt[d] > 0) begin
            if (pkt_ready) begin
                for (int i = 0; i < 3; i++) m_q[d][i] = m_q[d][i+1];
                m_cnt[d]--;
                if (m_cnt[d] == 0) begin
                    if (m_need[d] == 0) m_fin[d] = 1;
                    else if (m_need[d] < n_ts(d)) m_ts[d]++;
                end
            end
        end else if (ifmap_valid) begin
            m_push(d, exp_if(ifmap_in, m_ts[d]));
            m_need[d]--;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_run[d] = 0; m_fin[d] = 0; m_need[d] = 0; m_ts[d] = 0; m_cnt[d] = 0;
            end
        end else begin
            m_step(0);
            m_step(1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- event logs ----------------
    logic [27:0] lg_dat[64];
    int          lg_cyc[64];
    int          lg_n = 0, dn0_n = 0, dn0_cyc = 0, dn1_n = 0, h1_n = 0, hs1 = 0;
    logic        h1[64];

    always @(negedge clk) begin
        if (pkt_valid0 && pkt_ready) begin
            lg_dat[lg_n % 64] <= pkt_data0;
            lg_cyc[lg_n % 64] <= cyc;
            lg_n <= lg_n + 1;
        end
        if (done0) begin
            dn0_n   <= dn0_n + 1;
            dn0_cyc <= cyc;
        end
        if (done1) dn1_n <= dn1_n + 1;
        if (pkt_valid1 && pkt_ready && !pkt_data1[1]) begin
            h1[h1_n % 64] <= pkt_data1[0];
            h1_n <= h1_n + 1;
        end
        if (ifmap_valid && ifmap_ready1) hs1 <= hs1 + 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_dut(input int d, input logic v, input logic [27:0] dat, input logic ir,
                           input logic bz, input logic dn, input int tsv);
        chk($sformatf("d%0d_pkt_valid", d), 32'(v), 32'(m_cnt[d] > 0));
        if (m_cnt[d] > 0) chk($sformatf("d%0d_pkt_data", d), 32'(dat), 32'(m_q[d][0]));
        chk($sformatf("d%0d_ifmap_ready", d), 32'(ir),
            32'(m_run[d] && !m_fin[d] && m_cnt[d] == 0 && m_need[d] > 0));
        chk($sformatf("d%0d_busy", d), 32'(bz), 32'(m_run[d]));
        chk($sformatf("d%0d_done", d), 32'(dn), 32'(m_fin[d]));
        chk($sformatf("d%0d_ts_idx", d), 32'(tsv), 32'(m_ts[d] & ((d == 0) ? 1 : 3)));
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) break;
        end
        chk("idle_within_budget", {30'd0, busy0, busy1}, 32'd0);
    endtask

    function automatic logic [71:0] r72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    int b, d0, d1, hb, hsb, t0;

    initial begin
        fork
            forever begin
                @(negedge clk);
                cmp_dut(0, pkt_valid0, pkt_data0, ifmap_ready0, busy0, done0, int'(ts_idx0));
                cmp_dut(1, pkt_valid1, pkt_data1, ifmap_ready1, busy1, done1, int'(ts_idx1));
            end
        join_none

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid0), 0);
        chk("rst_pkt_data", 32'(pkt_data0), 0);
        chk("rst_ifmap_ready", 32'(ifmap_ready0), 0);
        chk("rst_busy", {30'd0, busy0, busy1}, 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_ts_idx", 32'(ts_idx0), 0);
        rst_n = 1'b1;

        // scenario 1: nominal run, plus start and filter_in disturbance mid-run
        b = lg_n; d0 = dn0_n; d1 = dn1_n; hb = h1_n; hsb = hs1;
        pkt_ready = 1'b1; ifmap_valid = 1'b1; filter_in = FILT;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            start     = (i == 0) || (i == 3);
            filter_in = (i == 0) ? FILT : r72();
            if (i == 1) t0 = cyc;
            ifmap_in  = win[(hs1 - hsb > 3) ? 3 : hs1 - hsb];
            if (i > 4 && !busy0 && !busy1) break;
        end
        start = 1'b0;
        chk("s1_idle", {30'd0, busy0, busy1}, 0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("s1_pkt%0d", k), 32'(lg_dat[(b + k) % 64]), 32'(lit[k]));
        chk("s1_row1_cycle", lg_cyc[b % 64], t0);
        chk("s1_row3_cycle", lg_cyc[(b + 2) % 64], t0 + 2);
        chk("s1_done_count", dn0_n - d0, 1);
        chk("s1_done_cycle", dn0_cyc, lg_cyc[(b + 4) % 64] + 1);
        chk("s1_t4_if_count", h1_n - hb, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("s1_t4_hdr_ts%0d", k), 32'(h1[(hb + k) % 64]), k % 2);
        chk("s1_t4_done_count", dn1_n - d1, 1);

        // scenario 2: backpressure on row 2, ifmap withheld after row 3
        ifmap_valid = 1'b0; pkt_ready = 1'b1; filter_in = FILT;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 pkt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s2_stall_valid", 32'(pkt_valid0), 1);
            chk("s2_stall_data", 32'(pkt_data0), 32'h040506A);
        end
        @(posedge clk); #1 pkt_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s2_row3_data", 32'(pkt_data0), 32'h070809E);
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("s2_wait_ifmap_ready", 32'(ifmap_ready0), 1);
            chk("s2_wait_pkt_valid", 32'(pkt_valid0), 0);
        end
        @(posedge clk); #1 ifmap_valid = 1'b1; ifmap_in = 9'h0F0;
        @(posedge clk); #1 ifmap_valid = 1'b0;
        @(negedge clk);
        chk("s2_if_valid", 32'(pkt_valid0), 1);
        chk("s2_if_data", 32'(pkt_data0), 32'h0001980);
        chk("s2_if_ts", 32'(ts_idx0), 0);
        ifmap_valid = 1'b1; ifmap_in = 9'($urandom);
        wait_idle(60);

        // scenario 3: reset while stalled in the t1 ifmap packet
        pkt_ready = 1'b1; ifmap_valid = 1'b1; ifmap_in = 9'($urandom);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifmap_ready0 && ts_idx0 == 1'b1) break;
        end
        pkt_ready = 1'b0;
        @(posedge clk); #1;
        chk("s3_pre_valid", 32'(pkt_valid0), 1);
        chk("s3_pre_ts", 32'(ts_idx0), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("s3_rst_pkt_valid", 32'(pkt_valid0), 0);
        chk("s3_rst_busy", {30'd0, busy0, busy1}, 0);
        chk("s3_rst_ts_idx", 32'(ts_idx0), 0);
        chk("s3_rst_ifmap_ready", {30'd0, ifmap_ready0, ifmap_ready1}, 0);
        @(posedge clk); #1 rst_n = 1'b1; start = 1'b1; filter_in = FILT; pkt_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("s3_restart_valid", 32'(pkt_valid0), 1);
        chk("s3_restart_row1", 32'(pkt_data0), 32'h0102036);
        wait_idle(60);

        // scenario 4: randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst_n       = 1'b1;
            start       = ($urandom_range(0, 7) == 0);
            filter_in   = r72();
            ifmap_valid = ($urandom_range(0, 2) != 0);
            ifmap_in    = 9'($urandom);
            pkt_ready   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; pkt_ready = 1'b1; ifmap_valid = 1'b1;
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
